ir_pulse_decoder: RTL and testbench

IR_PULSE_DECODER -- requirements
Module: ir_pulse_decoder

---
 rtl/ir_pulse_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_ir_pulse_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_pulse_decoder.sv
// Pulse-distance IR frame decoder: sync low, then mark/space coded bits, with an optional repeat frame.
// Define IR_PULSE_DECODER_REPEAT_EN to build in repeat-frame detection and the repeat timer.
module ir_pulse_decoder #(
  parameter int SBD            = 240_000,
  parameter int BSD            = 60_000,
  parameter int BBD0           = 60_000,
  parameter int BBD1           = 120_000,
  parameter int RBD            = 120_000,
  parameter int MARGIN         = 20_000,
  parameter int MESSAGE_LENGTH = 32,
  parameter int LSB_FIRST      = 0,
  parameter int TIMEOUT        = 12_000_000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      signal_in,
  output logic [MESSAGE_LENGTH-1:0] code_out,
  output logic                      new_code_out,
  output logic                      repeat_out,
  output logic [2:0]                error_out,
  output logic [2:0]                state_out
);

  localparam int MAX_SR  = (SBD > RBD) ? SBD : RBD;
  localparam int MAX_ALL = (MAX_SR > BBD1) ? MAX_SR : BBD1;
  localparam int CW      = $clog2(MAX_ALL + MARGIN + 1) + 1;
  localparam int BW      = $clog2(MESSAGE_LENGTH + 1);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] SYNC_LIM  = CW'(MAX_SR + MARGIN);
  localparam logic [CW-1:0] MARK_LIM  = CW'(BSD + MARGIN);
  localparam logic [CW-1:0] SPACE_LIM = CW'(BBD1 + MARGIN);
  localparam logic [BW-1:0] LAST_BIT  = BW'(MESSAGE_LENGTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_MARK  = 3'd2;
  localparam logic [2:0] ST_SPACE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef IR_PULSE_DECODER_REPEAT_EN
  localparam logic [2:0] ST_RPT   = 3'd5;
  localparam int         RW       = $clog2(TIMEOUT + 1) + 1;
  localparam logic [RW-1:0] TMR_MAX = {RW{1'b1}};
  localparam logic [RW-1:0] TMR_LIM = RW'(TIMEOUT);
`endif

  logic                      sync1_r;
  logic                      s_r;
  logic                      prev_r;
  logic                      rise_s;
  logic                      fall_s;
  logic [CW-1:0]             cnt_r;
  logic [2:0]                state_r;
  logic [BW-1:0]             bit_cnt_r;
  logic [MESSAGE_LENGTH-1:0] buf_r;
  logic [MESSAGE_LENGTH-1:0] buf_next_s;
  logic                      pend_r;
  logic                      new_bit_s;
  logic                      m_sbd_s;
  logic                      m_bsd_s;
  logic                      m_bbd0_s;
  logic                      m_bbd1_s;
`ifdef IR_PULSE_DECODER_REPEAT_EN
  logic                      m_rbd_s;
  logic                      repeat_r;
  logic [RW-1:0]             tmr_r;
`endif

  // Inclusive tolerance window around a target duration.
  function automatic logic match_f(input logic [CW-1:0] d, input int unsigned t);
    logic [31:0] dv;
    dv = 32'(d);
    return ((dv + 32'(MARGIN)) >= 32'(t)) && (dv <= (32'(t) + 32'(MARGIN)));
  endfunction

  assign rise_s   = s_r & ~prev_r;
  assign fall_s   = ~s_r & prev_r;
  assign m_sbd_s  = match_f(cnt_r, SBD);
  assign m_bsd_s  = match_f(cnt_r, BSD);
  assign m_bbd0_s = match_f(cnt_r, BBD0);
  assign m_bbd1_s = match_f(cnt_r, BBD1);
  assign new_bit_s = ~m_bbd0_s;
  assign state_out = state_r;
`ifdef IR_PULSE_DECODER_REPEAT_EN
  assign m_rbd_s    = match_f(cnt_r, RBD);
  assign repeat_out = repeat_r;
`else
  assign repeat_out = 1'b0;
`endif

  // Buffer contents after shifting in the bit decoded from the current space.
  always_comb begin
    buf_next_s = buf_r;
    if (LSB_FIRST != 0) begin
      buf_next_s = {new_bit_s, buf_r[MESSAGE_LENGTH-1:1]};
    end else begin
      buf_next_s = {buf_r[MESSAGE_LENGTH-2:0], new_bit_s};
    end
  end

  // Input synchronizer, edge history and saturating run-length counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_r <= 1'b1;
      s_r     <= 1'b1;
      prev_r  <= 1'b1;
      cnt_r   <= '0;
    end else begin
      sync1_r <= signal_in;
      s_r     <= sync1_r;
      prev_r  <= s_r;
      if (rise_s || fall_s) begin
        cnt_r <= CW'(1);
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Frame FSM; the run length is judged on the cycle the closing edge is seen.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= '0;
      buf_r        <= '0;
      code_out     <= '0;
      new_code_out <= 1'b0;
      error_out    <= 3'd0;
      pend_r       <= 1'b0;
`ifdef IR_PULSE_DECODER_REPEAT_EN
      repeat_r     <= 1'b0;
      tmr_r        <= TMR_MAX;
`endif
    end else begin
      new_code_out <= 1'b0;
      // DONE does not look at the line, so a falling edge there is replayed in IDLE.
      pend_r       <= fall_s && (state_r == ST_DONE);
`ifdef IR_PULSE_DECODER_REPEAT_EN
      repeat_r     <= 1'b0;
      if (tmr_r != TMR_MAX) begin
        tmr_r <= tmr_r + RW'(1);
      end
`endif
      case (state_r)
        ST_IDLE: begin
          if (fall_s || pend_r) begin
            state_r   <= ST_SYNC;
            bit_cnt_r <= '0;
            buf_r     <= '0;
            error_out <= 3'd0;
          end
        end
        ST_SYNC: begin
          if (rise_s) begin
            if (m_sbd_s) begin
              state_r <= ST_MARK;
`ifdef IR_PULSE_DECODER_REPEAT_EN
            end else if (m_rbd_s) begin
              state_r <= ST_RPT;
`endif
            end else begin
              state_r   <= ST_IDLE;
              error_out <= 3'd1;
            end
          end else if (cnt_r > SYNC_LIM) begin
            state_r   <= ST_IDLE;
            error_out <= 3'd2;
          end
        end
        ST_MARK: begin
          if (fall_s) begin
            if (m_bsd_s) begin
              state_r <= ST_SPACE;
            end else begin
              state_r   <= ST_IDLE;
              error_out <= 3'd3;
            end
          end else if (cnt_r > MARK_LIM) begin
            state_r   <= ST_IDLE;
            error_out <= 3'd3;
          end
        end
        ST_SPACE: begin
          if (rise_s) begin
            if (m_bbd0_s || m_bbd1_s) begin
              buf_r     <= buf_next_s;
              bit_cnt_r <= bit_cnt_r + BW'(1);
              if ((bit_cnt_r + BW'(1)) == LAST_BIT) begin
                code_out     <= buf_next_s;
                new_code_out <= 1'b1;
                state_r      <= ST_DONE;
              end else begin
                state_r <= ST_MARK;
              end
            end else begin
              state_r   <= ST_IDLE;
              error_out <= 3'd4;
            end
          end else if (cnt_r > SPACE_LIM) begin
            state_r   <= ST_IDLE;
            error_out <= 3'd4;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
`ifdef IR_PULSE_DECODER_REPEAT_EN
          tmr_r   <= '0;
`endif
        end
`ifdef IR_PULSE_DECODER_REPEAT_EN
        ST_RPT: begin
          if (fall_s) begin
            state_r <= ST_IDLE;
            if (m_bsd_s && (tmr_r <= TMR_LIM)) begin
              repeat_r <= 1'b1;
              tmr_r    <= '0;
            end else begin
              error_out <= 3'd5;
            end
          end else if (cnt_r > MARK_LIM) begin
            state_r   <= ST_IDLE;
            error_out <= 3'd5;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_pulse_decoder.sv
// Directed bench for ir_pulse_decoder: an MSB-first and an LSB-first instance, each with its own line.
module tb_ir_pulse_decoder;

  localparam int ML = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig_m = 1'b1;
  logic          sig_l = 1'b1;
  logic [ML-1:0] code_m, code_l;
  logic          nc_m, nc_l, rp_m, rp_l;
  logic [2:0]    err_m, err_l, st_m, st_l;

  int checks = 0;
  int failures = 0;
  int new_m_cyc = 0;
  int new_l_cyc = 0;
  int rep_cyc = 0;
  int both_cyc = 0;
  int snap;

  always #5 clk = ~clk;

  ir_pulse_decoder #(.SBD(240), .BSD(60), .BBD0(60), .BBD1(120), .RBD(120), .MARGIN(20),
                     .MESSAGE_LENGTH(ML), .LSB_FIRST(0), .TIMEOUT(2000)) dut_m (
    .clk_in(clk), .rst_in(rst), .signal_in(sig_m), .code_out(code_m), .new_code_out(nc_m),
    .repeat_out(rp_m), .error_out(err_m), .state_out(st_m));

  ir_pulse_decoder #(.SBD(240), .BSD(60), .BBD0(60), .BBD1(120), .RBD(120), .MARGIN(20),
                     .MESSAGE_LENGTH(ML), .LSB_FIRST(1), .TIMEOUT(2000)) dut_l (
    .clk_in(clk), .rst_in(rst), .signal_in(sig_l), .code_out(code_l), .new_code_out(nc_l),
    .repeat_out(rp_l), .error_out(err_l), .state_out(st_l));

  always @(negedge clk) begin
    if (nc_m) new_m_cyc++;
    if (nc_l) new_l_cyc++;
    if (rp_m || rp_l) rep_cyc++;
    if ((nc_m && rp_m) || (nc_l && rp_l)) both_cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ln, input logic v, input int n);
    if (ln) sig_l = v;
    else sig_m = v;
    repeat (n) @(negedge clk);
  endtask

  // Sends bits in the receiving instance's own order; stop_bit aborts the frame there.
  task automatic send_frame(input bit ln, input logic [7:0] code, input int sync_len, input int mark_len,
                            input int sp0, input int sp1, input int stop_bit, input int stop_len);
    logic b;
    drive(ln, 1'b0, sync_len);
    for (int i = 0; i < 8; i++) begin
      b = ln ? code[i] : code[7-i];
      if (i == stop_bit) begin
        if (stop_len > 0) begin
          drive(ln, 1'b1, mark_len);
          drive(ln, 1'b0, stop_len);
        end else begin
          drive(ln, 1'b1, mark_len / 2);
        end
        drive(ln, 1'b1, 0);
        return;
      end
      drive(ln, 1'b1, mark_len);
      drive(ln, 1'b0, b ? sp1 : sp0);
    end
    drive(ln, 1'b1, 0);
  endtask

  // Final edge reaches s two clocks after the drive; the strobe follows one clock later.
  task automatic check_done(input bit ln, input logic [7:0] exp, input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_pre"}, ln ? nc_l : nc_m, 1'b0);
    @(negedge clk);
    chk({tag, "_strobe"}, ln ? nc_l : nc_m, 1'b1);
    chk({tag, "_code"}, ln ? code_l : code_m, exp);
    chk({tag, "_err"}, ln ? err_l : err_m, 3'd0);
    @(negedge clk);
    chk({tag, "_post"}, ln ? nc_l : nc_m, 1'b0);
    chk({tag, "_idle"}, ln ? st_l : st_m, 3'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic repeat_seq();
    drive(1'b0, 1'b0, 120);
    drive(1'b0, 1'b1, 60);
    drive(1'b0, 1'b0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_code", code_m, 8'h00);
    chk("rst_new", nc_m, 1'b0);
    chk("rst_rep", rp_m, 1'b0);
    chk("rst_err", err_m, 3'd0);
    chk("rst_state", st_m, 3'd0);
    chk("rst_code_l", code_l, 8'h00);
    repeat (10) @(negedge clk);

    send_frame(1'b0, 8'hA5, 240, 60, 60, 120, -1, 0);
    check_done(1'b0, 8'hA5, "msb_a5");
    send_frame(1'b0, 8'h12, 240, 60, 60, 120, -1, 0);
    check_done(1'b0, 8'h12, "msb_12");

    send_frame(1'b1, 8'hA5, 240, 60, 60, 120, -1, 0);
    check_done(1'b1, 8'hA5, "lsb_a5");
    send_frame(1'b1, 8'h12, 240, 60, 60, 120, -1, 0);
    check_done(1'b1, 8'h12, "lsb_12");
    send_frame(1'b1, 8'hA5, 220, 80, 60, 140, -1, 0);
    check_done(1'b1, 8'hA5, "lsb_bnd_hi");
    send_frame(1'b1, 8'h12, 260, 40, 80, 100, -1, 0);
    check_done(1'b1, 8'h12, "lsb_bnd_lo");
    drive(1'b1, 1'b0, 219);
    drive(1'b1, 1'b1, 4);
    chk("sync219_err", err_l, 3'd1);
    chk("sync219_state", st_l, 3'd0);
    chk("sync219_code", code_l, 8'h12);

    drive(1'b0, 1'b0, 300);
    drive(1'b0, 1'b1, 4);
    chk("sync_to_err", err_m, 3'd2);
    chk("sync_to_state", st_m, 3'd0);

    snap = new_m_cyc;
    send_frame(1'b0, 8'hFF, 240, 60, 60, 120, 3, 95);
    repeat (4) @(negedge clk);
    chk("sp95_err", err_m, 3'd4);
    chk("sp95_state", st_m, 3'd0);
    chk("sp95_nostrobe", new_m_cyc, snap);
    chk("sp95_code", code_m, 8'h12);
    send_frame(1'b0, 8'h3C, 240, 60, 60, 120, -1, 0);
    check_done(1'b0, 8'h3C, "msb_3c");

    drive(1'b0, 1'b0, 240);
    drive(1'b0, 1'b1, 95);
    chk("mark_to_err", err_m, 3'd3);
    chk("mark_to_state", st_m, 3'd0);
    chk("mark_to_code", code_m, 8'h3C);

    send_frame(1'b0, 8'hFF, 240, 60, 60, 120, 4, 0);
    chk("mid_bit4_state", st_m, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("srst_code", code_m, 8'h00);
    chk("srst_new", nc_m, 1'b0);
    chk("srst_rep", rp_m, 1'b0);
    chk("srst_err", err_m, 3'd0);
    chk("srst_state", st_m, 3'd0);
    chk("srst_code_l", code_l, 8'h00);
    repeat (10) @(negedge clk);
    snap = new_m_cyc;
    send_frame(1'b0, 8'h81, 240, 60, 60, 120, -1, 0);
    check_done(1'b0, 8'h81, "msb_81");
    chk("msb_81_once", new_m_cyc - snap, 1);

    send_frame(1'b0, 8'h5A, 240, 60, 60, 120, -1, 0);
    check_done(1'b0, 8'h5A, "msb_5a");
    repeat (1000) @(negedge clk);
    repeat_seq();
    repeat (2) @(negedge clk);
    chk("rpt1_pre", rp_m, 1'b0);
    @(negedge clk);
`ifdef IR_PULSE_DECODER_REPEAT_EN
    chk("rpt1_strobe", rp_m, 1'b1);
`else
    chk("rpt1_nostrobe", rp_m, 1'b0);
`endif
    chk("rpt1_code", code_m, 8'h5A);
    @(negedge clk);
    chk("rpt1_post", rp_m, 1'b0);
    drive(1'b0, 1'b0, 56);
    drive(1'b0, 1'b1, 4);
`ifdef IR_PULSE_DECODER_REPEAT_EN
    chk("rpt1_err", err_m, 3'd0);
`else
    chk("rpt1_err", err_m, 3'd1);
`endif
    repeat (3000) @(negedge clk);
    repeat_seq();
    drive(1'b0, 1'b0, 60);
    drive(1'b0, 1'b1, 4);
`ifdef IR_PULSE_DECODER_REPEAT_EN
    chk("rpt2_err", err_m, 3'd5);
    chk("rpt_count", rep_cyc, 1);
`else
    chk("rpt2_err", err_m, 3'd1);
    chk("rpt_count", rep_cyc, 0);
`endif
    chk("rpt2_code", code_m, 8'h5A);

    chk("new_m_total", new_m_cyc, 5);
    chk("new_l_total", new_l_cyc, 4);
    chk("strobe_overlap", both_cyc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
